range_stream_sender: RTL and testbench

Transmit side of the range-finder sample interface. Buffers a burst of samples written by the host. On `start` it drives them onto the `data_in`/`go`/`finish` stream a range-finder consumes: `go` with the first sample, `finish` with the last. One cycle after `finish` it captures the finder's `range`/`error` response and reports it with a `done` pulse. It sits between the host/test controller and a range-finder instance.

---
 rtl/range_stream_sender_if.sv | 50 +++++
 rtl/range_stream_sender.sv | 147 ++++++++++++++
 tb/tb_range_stream_sender.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/range_stream_sender_if.sv
// range_stream_sender_if
// Purpose: bundles the host-facing buffer controls, the range-finder
// stream and the captured result of range_stream_sender into one port.
//
// Handshake semantics:
//   Host writes (wr_en/wr_data) are accepted only while the sender is idle
//   and not full. There is no per-word ready. buf_full and overflow report
//   back-pressure after the fact. start is a single-cycle request.
//   start_err (rejected) and done (result updated) are single-cycle pulses.
//   go marks the first stream word and finish the last. The finder must
//   present range/error in the cycle after finish.
//
// Modports:
//   master - the sender (drives the stream and status, reads host and finder)
//   slave  - host and finder side (drives writes/start and finder response)
interface range_stream_sender_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [CW-1:0]    buf_count;
  logic             buf_full;
  logic             overflow;
  logic             start_err;
  logic             busy;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;
  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             done;

  modport master (
    input  wr_en, wr_data, start, rf_range, rf_error,
    output buf_count, buf_full, overflow, start_err, busy,
           data_out, go, finish, result, result_err, done
  );

  modport slave (
    output wr_en, wr_data, start, rf_range, rf_error,
    input  buf_count, buf_full, overflow, start_err, busy,
           data_out, go, finish, result, result_err, done
  );
endinterface

// File: rtl/range_stream_sender.sv
// range_stream_sender
// Purpose: buffers a burst of host samples in a DEPTH-word FIFO. On start,
// it streams the burst to a range-finder (go with the first word, finish
// with the last). It then captures the finder's range/error one cycle
// after finish and pulses done.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   bus          range_stream_sender_if.master (host writes, stream, result)
//   o_dbg_state  current FSM state (IDLE=0 FIRST=1 MID=2 LAST=3 CAPTURE=4)
module range_stream_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  range_stream_sender_if.master bus,
  output logic [2:0]           o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    MID     = 3'd2,
    LAST    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_start_err;
  logic             r_busy;
  logic [WIDTH-1:0] r_data_out;
  logic             r_go;
  logic             r_finish;
  logic [WIDTH-1:0] r_result;
  logic             r_result_err;
  logic             r_done;

  logic w_full;
  logic w_wr_accept;

  assign w_full      = (r_count == CW'(DEPTH));
  // A start in the same cycle wins over a write, whether or not it is accepted.
  assign w_wr_accept = (r_state == IDLE) && bus.wr_en && !bus.start && !w_full;

  // Storage has no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_start_err  <= 1'b0;
      r_busy       <= 1'b0;
      r_data_out   <= '0;
      r_go         <= 1'b0;
      r_finish     <= 1'b0;
      r_result     <= '0;
      r_result_err <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_err <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (r_count >= CW'(2)) begin
              // Word 0 goes out now. The count then tracks the words still to send.
              r_state    <= FIRST;
              r_data_out <= r_mem[r_rd_ptr];
              r_go       <= 1'b1;
              r_rd_ptr   <= r_rd_ptr + AW'(1);
              r_count    <= r_count - CW'(1);
              r_busy     <= 1'b1;
              r_overflow <= 1'b0;
            end else begin
              r_start_err <= 1'b1;
            end
          end else if (bus.wr_en) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_count  <= r_count + CW'(1);
            end
          end
        end
        FIRST, MID: begin
          r_go       <= 1'b0;
          r_data_out <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_count    <= r_count - CW'(1);
          // One word left means the word being loaded now is the last one.
          if (r_count == CW'(1)) begin
            r_finish <= 1'b1;
            r_state  <= LAST;
          end else begin
            r_state <= MID;
          end
        end
        LAST: begin
          r_finish <= 1'b0;
          r_state  <= CAPTURE;
        end
        CAPTURE: begin
          // The finder registered its range on the finish edge, so it is stable now.
          r_result     <= bus.rf_range;
          r_result_err <= bus.rf_error;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.buf_count  = r_count;
  assign bus.buf_full   = w_full;
  assign bus.overflow   = r_overflow;
  assign bus.start_err  = r_start_err;
  assign bus.busy       = r_busy;
  assign bus.data_out   = r_data_out;
  assign bus.go         = r_go;
  assign bus.finish     = r_finish;
  assign bus.result     = r_result;
  assign bus.result_err = r_result_err;
  assign bus.done       = r_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_range_stream_sender.sv
module tb_range_stream_sender;

  localparam int W = 16;
  localparam int D = 16;

  logic       clock;
  logic       reset;
  logic [2:0] dbg_state;

  range_stream_sender_if #(.WIDTH(W), .DEPTH(D)) bus ();

  range_stream_sender #(.WIDTH(W), .DEPTH(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];   // expected stream words
  logic [W:0]   res_q[$];   // expected {result_err, result}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- range-finder model ----------------
  // Real finder: range = max - min over the burst, registered on the finish edge.
  logic         stub_mode = 1'b0;
  logic [W-1:0] f_min, f_max, f_range;

  function automatic logic [W-1:0] fmin(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic [W-1:0] fmax(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clock) begin
    if (bus.go) begin
      f_min <= bus.data_out;
      f_max <= bus.data_out;
    end else if (dbg_state == 3'd2) begin
      f_min <= fmin(f_min, bus.data_out);
      f_max <= fmax(f_max, bus.data_out);
    end
    if (bus.finish) begin
      f_range <= fmax(f_max, bus.data_out) - fmin(f_min, bus.data_out);
    end
  end

  assign bus.rf_range = stub_mode ? 16'hABCD : f_range;
  assign bus.rf_error = stub_mode;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.go || bus.finish || dbg_state == 3'd2) begin
        if (exp_q.size() == 0) check("stream_extra_word", {16'd0, bus.data_out}, 32'hFFFF_FFFF);
        else check("stream_data", {16'd0, bus.data_out}, {16'd0, exp_q.pop_front()});
      end
      if (bus.go || bus.finish) check("go_finish_exclusive", {31'd0, bus.go & bus.finish}, 32'd0);
      if (bus.go) check("go_in_first", {29'd0, dbg_state}, 32'd1);
      if (bus.finish) check("finish_in_last", {29'd0, dbg_state}, 32'd3);
      if (bus.done) begin
        if (res_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("result", {15'd0, bus.result_err, bus.result}, {15'd0, res_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic write_word(input logic [W-1:0] v, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    if (accept) exp_q.push_back(v);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    check(tag, {31'd0, bus.done}, 32'd1);
    cyc();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    repeat (3) cyc();
    check("rst_buf_count", {27'd0, bus.buf_count}, 32'd0);
    check("rst_flags", {26'd0, bus.buf_full, bus.overflow, bus.start_err, bus.busy, bus.go, bus.finish}, 32'd0);
    check("rst_result", {15'd0, bus.result_err, bus.result}, 32'd0);
    check("rst_data_done", {15'd0, bus.done, bus.data_out}, 32'd0);
    reset = 1'b0;
    cyc();

    // Burst 5,9,3,7 with exact cycle timing.
    write_word(16'd5, 1'b1);
    write_word(16'd9, 1'b1);
    write_word(16'd3, 1'b1);
    write_word(16'd7, 1'b1);
    check("t1_count4", {27'd0, bus.buf_count}, 32'd4);
    res_q.push_back({1'b0, 16'd6});
    do_start();                                      // now in T+1
    check("t1_go_t1", {31'd0, bus.go}, 32'd1);
    check("t1_busy_t1", {31'd0, bus.busy}, 32'd1);
    repeat (3) cyc();                                // T+4
    check("t1_finish_t4", {31'd0, bus.finish}, 32'd1);
    cyc();                                           // T+5
    check("t1_capture_t5", {30'd0, bus.busy, bus.done}, 32'd2);
    cyc();                                           // T+6
    check("t1_done_t6", {31'd0, bus.done}, 32'd1);
    check("t1_idle_t6", {26'd0, bus.busy, bus.buf_count}, 32'd0);
    cyc();
    check("t1_done_pulse", {31'd0, bus.done}, 32'd0);

    // Single-word start is rejected, then a 2-word burst.
    write_word(16'h0042, 1'b1);
    do_start();
    check("t2_start_err", {31'd0, bus.start_err}, 32'd1);
    check("t2_no_go", {30'd0, bus.go, bus.busy}, 32'd0);
    check("t2_count1", {27'd0, bus.buf_count}, 32'd1);
    cyc();
    check("t2_start_err_pulse", {31'd0, bus.start_err}, 32'd0);
    write_word(16'h0010, 1'b1);
    res_q.push_back({1'b0, 16'h0032});
    do_start();
    wait_done("t2_done");

    // Overflow: 17 writes, the last is dropped.
    for (int i = 1; i <= 16; i++) write_word(W'(i), 1'b1);
    check("t3_full", {31'd0, bus.buf_full}, 32'd1);
    check("t3_no_overflow_yet", {31'd0, bus.overflow}, 32'd0);
    write_word(16'd17, 1'b0);
    check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
    check("t3_count16", {27'd0, bus.buf_count}, 32'd16);
    res_q.push_back({1'b0, 16'd15});
    do_start();
    check("t3_overflow_cleared", {31'd0, bus.overflow}, 32'd0);
    wait_done("t3_done");
    check("t3_empty", {27'd0, bus.buf_count}, 32'd0);

    // Stub finder reporting an error.
    stub_mode = 1'b1;
    write_word(16'h1111, 1'b1);
    write_word(16'h2222, 1'b1);
    write_word(16'h3333, 1'b1);
    res_q.push_back({1'b1, 16'hABCD});
    do_start();
    wait_done("t4_done");
    check("t4_single_done", {31'd0, bus.done}, 32'd0);
    stub_mode = 1'b0;

    // Writes and start during busy are ignored.
    write_word(16'd10, 1'b1);
    write_word(16'd20, 1'b1);
    write_word(16'd30, 1'b1);
    write_word(16'd40, 1'b1);
    res_q.push_back({1'b0, 16'd30});
    do_start();
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hFFFF;
    bus.start   = 1'b1;
    begin
      int n = 0;
      while (bus.busy === 1'b1 && n < 30) begin
        check("t5_no_start_err", {31'd0, bus.start_err}, 32'd0);
        cyc();
        n++;
      end
    end
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("t5_done", {31'd0, bus.done}, 32'd1);
    check("t5_count0", {27'd0, bus.buf_count}, 32'd0);
    cyc();
    check("t5_no_late_err", {31'd0, bus.start_err}, 32'd0);

    // Reset in MID aborts the burst.
    for (int i = 1; i <= 5; i++) write_word(W'(i * 3), 1'b1);
    do_start();
    cyc();
    check("t6_in_mid", {29'd0, dbg_state}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_abort_outputs", {26'd0, bus.go, bus.finish, bus.busy, bus.done, 2'b00}, 32'd0);
    check("t6_abort_count", {27'd0, bus.buf_count}, 32'd0);
    check("t6_abort_data", {16'd0, bus.data_out}, 32'd0);
    exp_q.delete();
    cyc();
    reset = 1'b0;
    cyc();
    write_word(16'h0100, 1'b1);
    write_word(16'h0180, 1'b1);
    res_q.push_back({1'b0, 16'h0080});
    do_start();
    wait_done("t6_done");

    check("end_stream_queue_empty", exp_q.size(), 32'd0);
    check("end_result_queue_empty", res_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
